// File: rtl/nec_prefetch_ctrl_pkg.sv
// Shared types for the NEC prefetch controller: FSM state enum,
// queue size/depth constants and the code fetch address helper.
// PREFETCH_DEPTH6_EN selects the 6-byte (V30) queue depth.
package nec_prefetch_ctrl_pkg;

    typedef enum logic [1:0] {
        UNSYNC,
        IDLE,
        FETCH,
        EU
    } prefetch_state_e;

    localparam int IPQ_SIZE = 8;

`ifdef PREFETCH_DEPTH6_EN
    localparam logic [3:0] IPQ_DEPTH = 4'd6;
`else
    localparam logic [3:0] IPQ_DEPTH = 4'd8;
`endif

    function automatic logic [19:0] code_addr(
        input logic [15:0] seg,
        input logic [15:0] ofs
    );
        return {seg, 4'h0} + {4'h0, ofs};
    endfunction

endpackage

// File: rtl/nec_prefetch_buf.sv
// 8x8 circular instruction byte buffer with one word/byte write port.
// Ports: clk, reset_n, we, word, idx, wdata in; q (all bytes) out.
import nec_prefetch_ctrl_pkg::*;

module nec_prefetch_buf (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic                     word,
    input  logic [2:0]               idx,
    input  logic [15:0]              wdata,
    output logic [IPQ_SIZE-1:0][7:0] q
);

    logic [2:0] idx_hi;

    // Second byte of a word write wraps around the buffer.
    assign idx_hi = idx + 3'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (we) begin
            if (word) begin
                q[idx]    <= wdata[7:0];
                q[idx_hi] <= wdata[15:8];
            end else begin
                // Odd address: the byte arrives on the high lane.
                q[idx] <= wdata[15:8];
            end
        end
    end

endmodule

// File: rtl/nec_prefetch_ctrl.sv
// Prefetch queue filler sharing the 16-bit bus between code fetch
// and EU data cycles; tracks fetch_pc and computes ipq_len.
// Ports: clk/reset_n/ce_1/ce_2; decoder side ps, decode_pc, set_pc,
// new_pc, block_prefetch, ipq, ipq_len; EU side eu_req..eu_rdata;
// bus side bus_req..bus_rdata. Macro PREFETCH_DEPTH6_EN: depth 6.
import nec_prefetch_ctrl_pkg::*;

module nec_prefetch_ctrl (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce_1,
    input  logic             ce_2,
    input  logic [15:0]      ps,
    input  logic [15:0]      decode_pc,
    input  logic             set_pc,
    input  logic [15:0]      new_pc,
    input  logic             block_prefetch,
    output logic [7:0][7:0]  ipq,
    output logic [3:0]       ipq_len,
    input  logic             eu_req,
    input  logic             eu_write,
    input  logic [19:0]      eu_addr,
    input  logic [1:0]       eu_be,
    input  logic [15:0]      eu_wdata,
    output logic             eu_ack,
    output logic [15:0]      eu_rdata,
    output logic             bus_req,
    output logic             bus_write,
    output logic [19:0]      bus_addr,
    output logic [1:0]       bus_be,
    output logic [15:0]      bus_wdata,
    input  logic             bus_ready,
    input  logic [15:0]      bus_rdata
);

    prefetch_state_e state, state_n;

    logic [15:0] fetch_pc;
    logic        discard;
    logic [3:0]  len_raw;
    logic        room;
    logic        fetch_ok;
    logic        issue_eu;
    logic        issue_fetch;
    logic        done;
    logic        commit;
    logic        fetch_word;

    // Only the low nibble of decode_pc matters for the length.
    logic unused_ok;
    assign unused_ok = ^{ce_2, decode_pc[15:4]};

    assign len_raw = fetch_pc[3:0] - decode_pc[3:0];
    assign ipq_len = (state == UNSYNC) ? 4'd0 : len_raw;

    assign fetch_word = ~fetch_pc[0];

    // Compare against depth instead of subtracting, so a transiently
    // inconsistent decode_pc cannot underflow the free count.
    assign room = fetch_word ? (ipq_len <= IPQ_DEPTH - 4'd2)
                             : (ipq_len <= IPQ_DEPTH - 4'd1);

    assign fetch_ok = (state == IDLE) & ~block_prefetch
                    & ~set_pc & room;

    always_comb begin
        state_n     = state;
        issue_eu    = 1'b0;
        issue_fetch = 1'b0;
        done        = 1'b0;
        unique case (state)
            UNSYNC: begin
                if (set_pc)
                    state_n = IDLE;
            end
            IDLE: begin
                if (eu_req) begin
                    state_n  = EU;
                    issue_eu = 1'b1;
                end else if (fetch_ok) begin
                    state_n     = FETCH;
                    issue_fetch = 1'b1;
                end
            end
            FETCH: begin
                if (bus_ready) begin
                    state_n = IDLE;
                    done    = 1'b1;
                end
            end
            EU: begin
                if (bus_ready) begin
                    state_n = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_n = UNSYNC;
        endcase
    end

    // A redirect landing with bus_ready drops the data as well.
    assign commit = (state == FETCH) & bus_ready
                  & ~discard & ~set_pc;

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= UNSYNC;
        else if (ce_1)
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc  <= '0;
            discard   <= 1'b0;
            bus_req   <= 1'b0;
            bus_write <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            eu_ack    <= 1'b0;
            eu_rdata  <= '0;
        end else if (ce_1) begin
            eu_ack <= 1'b0;

            if (set_pc)
                fetch_pc <= new_pc;
            else if (commit)
                fetch_pc <= fetch_pc
                          + (fetch_word ? 16'd2 : 16'd1);

            if (state == FETCH) begin
                if (bus_ready)
                    discard <= 1'b0;
                else if (set_pc)
                    discard <= 1'b1;
            end

            if (issue_eu) begin
                bus_req   <= 1'b1;
                bus_write <= eu_write;
                bus_addr  <= eu_addr;
                bus_be    <= eu_be;
                bus_wdata <= eu_wdata;
            end else if (issue_fetch) begin
                bus_req   <= 1'b1;
                bus_write <= 1'b0;
                bus_addr  <= code_addr(ps, fetch_pc);
                bus_be    <= fetch_word ? 2'b11 : 2'b10;
                bus_wdata <= '0;
            end else if (done) begin
                bus_req <= 1'b0;
            end

            if (state == EU && bus_ready) begin
                eu_ack   <= 1'b1;
                eu_rdata <= bus_rdata;
            end
        end
    end

    nec_prefetch_buf u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ce_1 & commit),
        .word    (fetch_word),
        .idx     (fetch_pc[2:0]),
        .wdata   (bus_rdata),
        .q       (ipq)
    );

endmodule

// File: tb/tb_nec_prefetch_ctrl.sv
// Directed bench for nec_prefetch_ctrl: fill, odd redirect, flush,
// EU priority, blocking and 16-bit wrap with hand-computed values.
module tb_nec_prefetch_ctrl;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            ce_1;
    logic            ce_2;
    logic [15:0]     ps;
    logic [15:0]     decode_pc;
    logic            set_pc;
    logic [15:0]     new_pc;
    logic            block_prefetch;
    logic [7:0][7:0] ipq;
    logic [3:0]      ipq_len;
    logic            eu_req;
    logic            eu_write;
    logic [19:0]     eu_addr;
    logic [1:0]      eu_be;
    logic [15:0]     eu_wdata;
    logic            eu_ack;
    logic [15:0]     eu_rdata;
    logic            bus_req;
    logic            bus_write;
    logic [19:0]     bus_addr;
    logic [1:0]      bus_be;
    logic [15:0]     bus_wdata;
    logic            bus_ready;
    logic [15:0]     bus_rdata;

`ifdef PREFETCH_DEPTH6_EN
    localparam logic [63:0] FILL_IPQ = 64'h0000_A5A4_A3A2_A1A0;
    localparam logic [3:0]  FULL_LEN = 4'd6;
    localparam logic [15:0] FILL_END = 16'h0016;
`else
    localparam logic [63:0] FILL_IPQ = 64'hA7A6_A5A4_A3A2_A1A0;
    localparam logic [3:0]  FULL_LEN = 4'd8;
    localparam logic [15:0] FILL_END = 16'h0018;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] fill_v;
    int          seen;

    nec_prefetch_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ce_1           (ce_1),
        .ce_2           (ce_2),
        .ps             (ps),
        .decode_pc      (decode_pc),
        .set_pc         (set_pc),
        .new_pc         (new_pc),
        .block_prefetch (block_prefetch),
        .ipq            (ipq),
        .ipq_len        (ipq_len),
        .eu_req         (eu_req),
        .eu_write       (eu_write),
        .eu_addr        (eu_addr),
        .eu_be          (eu_be),
        .eu_wdata       (eu_wdata),
        .eu_ack         (eu_ack),
        .eu_rdata       (eu_rdata),
        .bus_req        (bus_req),
        .bus_write      (bus_write),
        .bus_addr       (bus_addr),
        .bus_be         (bus_be),
        .bus_wdata      (bus_wdata),
        .bus_ready      (bus_ready),
        .bus_rdata      (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got,
                       logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    // Wait for a fetch request, check it, then complete it.
    task automatic serve(string tag, logic [19:0] addr,
                         logic [1:0] be, logic [15:0] rd);
        int k = 0;
        while (!bus_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_req"}, 64'(bus_req), 64'd1);
        if (bus_req) begin
            chk({tag, "_addr"}, 64'(bus_addr), 64'(addr));
            chk({tag, "_be"}, 64'(bus_be), 64'(be));
            chk({tag, "_wr"}, 64'(bus_write), 64'd0);
            bus_ready = 1'b1;
            bus_rdata = rd;
            @(negedge clk);
            bus_ready = 1'b0;
            bus_rdata = '0;
            chk({tag, "_fall"}, 64'(bus_req), 64'd0);
        end
    endtask

    task automatic count_idle(int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus_req)
                hits++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        ce_1           = 1'b1;
        ce_2           = 1'b0;
        ps             = '0;
        decode_pc      = '0;
        set_pc         = 1'b0;
        new_pc         = '0;
        block_prefetch = 1'b0;
        eu_req         = 1'b0;
        eu_write       = 1'b0;
        eu_addr        = '0;
        eu_be          = '0;
        eu_wdata       = '0;
        bus_ready      = 1'b0;
        bus_rdata      = '0;
        fill_v         = FILL_IPQ;
        repeat (3) @(negedge clk);

        chk("rst_len", 64'(ipq_len), 64'd0);
        chk("rst_req", 64'(bus_req), 64'd0);
        chk("rst_addr", 64'(bus_addr), 64'd0);
        chk("rst_be", 64'(bus_be), 64'd0);
        chk("rst_ack", 64'(eu_ack), 64'd0);
        chk("rst_rdata", 64'(eu_rdata), 64'd0);
        chk("rst_ipq", ipq, 64'd0);

        // set_pc is ignored while ce_1 is low.
        reset_n   = 1'b1;
        ps        = 16'h1000;
        decode_pc = 16'h0010;
        new_pc    = 16'h0010;
        set_pc    = 1'b1;
        ce_1      = 1'b0;
        repeat (2) @(negedge clk);
        chk("ce_len", 64'(ipq_len), 64'd0);
        chk("ce_req", 64'(bus_req), 64'd0);
        ce_1 = 1'b1;
        @(negedge clk);
        set_pc = 1'b0;

        serve("f0", 20'h10010, 2'b11, 16'hA1A0);
        serve("f1", 20'h10012, 2'b11, 16'hA3A2);
        serve("f2", 20'h10014, 2'b11, 16'hA5A4);
`ifndef PREFETCH_DEPTH6_EN
        serve("f3", 20'h10016, 2'b11, 16'hA7A6);
`endif
        count_idle(6, seen);
        chk("full_idle", 64'(seen), 64'd0);
        chk("full_len", 64'(ipq_len), 64'(FULL_LEN));
        chk("full_ipq", ipq, FILL_IPQ);

        block_prefetch = 1'b1;
        decode_pc      = FILL_END - 16'd2;
        count_idle(5, seen);
        chk("blk_idle", 64'(seen), 64'd0);
        chk("blk_len", 64'(ipq_len), 64'd2);

        new_pc    = 16'h0003;
        decode_pc = 16'h0003;
        set_pc    = 1'b1;
        @(negedge clk);
        set_pc         = 1'b0;
        block_prefetch = 1'b0;
        serve("odd", 20'h10003, 2'b10, 16'h5A77);
        chk("odd_b3", 64'(ipq[3]), 64'h5A);
        chk("odd_len", 64'(ipq_len), 64'd1);
        serve("even", 20'h10004, 2'b11, 16'h2211);
        chk("even_b4", 64'(ipq[4]), 64'h11);
        chk("even_b5", 64'(ipq[5]), 64'h22);

        seen = 0;
        while (!bus_req && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        chk("fl_addr", 64'(bus_addr), 64'h10006);
        new_pc    = 16'h0100;
        decode_pc = 16'h0100;
        set_pc    = 1'b1;
        @(negedge clk);
        set_pc    = 1'b0;
        bus_ready = 1'b1;
        bus_rdata = 16'hBEEF;
        @(negedge clk);
        bus_ready = 1'b0;
        bus_rdata = '0;
        chk("fl_ipq", 64'(ipq[7:6]), 64'(fill_v[63:48]));
        chk("fl_len", 64'(ipq_len), 64'd0);
        chk("fl_req", 64'(bus_req), 64'd0);
        serve("redir", 20'h10100, 2'b11, 16'h0201);
        chk("redir_ipq", 64'(ipq[1:0]), 64'h0201);

        eu_req   = 1'b1;
        eu_write = 1'b0;
        eu_addr  = 20'h20000;
        eu_be    = 2'b11;
        @(negedge clk);
        chk("eu_req", 64'(bus_req), 64'd1);
        chk("eu_addr", 64'(bus_addr), 64'h20000);
        chk("eu_wr", 64'(bus_write), 64'd0);
        chk("eu_ack0", 64'(eu_ack), 64'd0);
        bus_ready = 1'b1;
        bus_rdata = 16'h1234;
        @(negedge clk);
        bus_ready = 1'b0;
        bus_rdata = '0;
        eu_req    = 1'b0;
        chk("eu_ack1", 64'(eu_ack), 64'd1);
        chk("eu_rdata", 64'(eu_rdata), 64'h1234);
        @(negedge clk);
        chk("eu_ack2", 64'(eu_ack), 64'd0);
        serve("post_eu", 20'h10102, 2'b11, 16'h0403);

        eu_req   = 1'b1;
        eu_write = 1'b1;
        eu_addr  = 20'h0ABCD;
        eu_be    = 2'b01;
        eu_wdata = 16'hCAFE;
        @(negedge clk);
        chk("euw_wr", 64'(bus_write), 64'd1);
        chk("euw_addr", 64'(bus_addr), 64'h0ABCD);
        chk("euw_be", 64'(bus_be), 64'h1);
        chk("euw_data", 64'(bus_wdata), 64'hCAFE);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready      = 1'b0;
        eu_req         = 1'b0;
        eu_write       = 1'b0;
        block_prefetch = 1'b1;
        chk("euw_ack", 64'(eu_ack), 64'd1);

        ps        = 16'hF000;
        new_pc    = 16'hFFFE;
        decode_pc = 16'hFFFE;
        set_pc    = 1'b1;
        @(negedge clk);
        set_pc         = 1'b0;
        block_prefetch = 1'b0;
        serve("wrap1", 20'hFFFFE, 2'b11, 16'hBBAA);
        chk("wrap1_ipq", 64'(ipq[7:6]), 64'hBBAA);
        serve("wrap2", 20'hF0000, 2'b11, 16'hDDCC);
        chk("wrap2_ipq", 64'(ipq[1:0]), 64'hDDCC);
        chk("wrap_len", 64'(ipq_len), 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
